// File: rtl/rtc_write_seq.sv
// Write sequencer for the RTC multiplexed AD bus: address phase, bus-released gap, data phase.
// Optional one-entry pending request buffer enabled by defining RTC_WR_QUEUE_EN.
module rtc_write_seq #(
    parameter int unsigned T_SU  = 4,
    parameter int unsigned T_PW  = 9,
    parameter int unsigned T_HD  = 4,
    parameter int unsigned T_GAP = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr_in,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       pend_full,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       ad,
    output logic [7:0] bus_out,
    output logic       bus_oe
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DATA_W = 8;

    localparam logic [CNT_W-1:0] LAST_SU  = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LAST_PW  = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LAST_HD  = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(T_GAP - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR_SU, ADDR_PW, ADDR_HD, GAP, DATA_SU, DATA_PW, DATA_HD, DONE
    } stateT;

    stateT              state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [DATA_W-1:0]  addrReg, dataReg, addrNext, dataNext;

`ifdef RTC_WR_QUEUE_EN
    logic               pendFull;
    logic [DATA_W-1:0]  pendAddr, pendData;

    // Buffer a request arriving mid-transaction; it is drained on the DONE handoff.
    always_ff @(posedge clk) begin
        if (reset) begin
            pendFull <= 1'b0;
            pendAddr <= '0;
            pendData <= '0;
        end else if (state == DONE && pendFull) begin
            pendFull <= 1'b0;
        end else if (start && !pendFull && state != IDLE && state != DONE) begin
            pendFull <= 1'b1;
            pendAddr <= addr_in;
            pendData <= data_in;
        end
    end

    assign pend_full = pendFull;
`else
    assign pend_full = 1'b0;
`endif

    // Next-state, capture and phase-counter logic.
    always_comb begin
        stateNext = state;
        addrNext  = addrReg;
        dataNext  = dataReg;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = ADDR_SU;
                    addrNext  = addr_in;
                    dataNext  = data_in;
                end
            end
            ADDR_SU: if (cnt == LAST_SU)  stateNext = ADDR_PW;
            ADDR_PW: if (cnt == LAST_PW)  stateNext = ADDR_HD;
            ADDR_HD: if (cnt == LAST_HD)  stateNext = GAP;
            GAP:     if (cnt == LAST_GAP) stateNext = DATA_SU;
            DATA_SU: if (cnt == LAST_SU)  stateNext = DATA_PW;
            DATA_PW: if (cnt == LAST_PW)  stateNext = DATA_HD;
            DATA_HD: if (cnt == LAST_HD)  stateNext = DONE;
            DONE: begin
                stateNext = IDLE;
`ifdef RTC_WR_QUEUE_EN
                if (pendFull) begin
                    stateNext = ADDR_SU;
                    addrNext  = pendAddr;
                    dataNext  = pendData;
                end
`endif
            end
            default: stateNext = IDLE;
        endcase
        cntNext = (stateNext != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
    end

    // State register plus outputs decoded from the upcoming state so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addrReg <= '0;
            dataReg <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            ad      <= 1'b1;
            bus_out <= '0;
            bus_oe  <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            addrReg <= addrNext;
            dataReg <= dataNext;
            busy    <= (stateNext != IDLE);
            done    <= (stateNext == DONE);
            cs_n    <= !(stateNext == ADDR_PW || stateNext == DATA_PW);
            wr_n    <= !(stateNext == ADDR_PW || stateNext == DATA_PW);
            rd_n    <= 1'b1;
            ad      <= !(stateNext == ADDR_SU || stateNext == ADDR_PW || stateNext == ADDR_HD);
            case (stateNext)
                ADDR_SU, ADDR_PW, ADDR_HD: begin
                    bus_oe  <= 1'b1;
                    bus_out <= addrNext;
                end
                DATA_SU, DATA_PW, DATA_HD: begin
                    bus_oe  <= 1'b1;
                    bus_out <= dataNext;
                end
                default: begin
                    bus_oe  <= 1'b0;
                    bus_out <= '0;
                end
            endcase
        end
    end

endmodule
